pipe_stage_skid_reg: RTL and testbench

//  Parametrised pipeline stage register for the IF/ID boundary and later stages.
//  - Carries a PC + instruction payload with a valid/ready handshake instead of a global freeze.
//  - Uses a 2-entry skid buffer, so in_ready is a registered signal
//    (no combinational path from out_ready to in_ready) at full throughput.
//  - Flush kills all buffered entries (branch taken / exception redirect).

---
 rtl/pipe_stage_skid_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Purpose : valid/ready pipeline stage register (PC + instruction) with a 2-entry skid buffer and flush.
// Latency : 1 cycle in->out when empty; sustains 1 entry/cycle.
// Backpres: in_ready is a flop (state != FULL) with no combinational path from out_ready.
//
// Ports:
//   clk, rst (async active-low), flush (sync kill of all entries)
//   in_valid/in_ready, pc_in, instruction_in     - upstream handshake + payload
//   out_valid/out_ready, pc_out, instruction_out - downstream handshake + head payload
//   occupancy                                     - entries held (0..2)
//   stall_cnt, bubble_cnt                         - saturating perf counters, present
//                                                   only when PIPE_PERF_CNT_EN is defined
module pipe_stage_skid_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [1:0]         occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_fire;
  logic               out_fire;

  assign in_fire         = in_valid & in_ready;
  assign out_fire        = out_valid & out_ready;
  assign pc_out          = main_pc;
  assign instruction_out = main_instr;
  assign occupancy       = state;

  // out_valid and in_ready are registered alongside the state so that neither
  // output depends combinationally on any input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      // Any in_fire this cycle is dropped; an out_fire already happened.
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      case (state)
        EMPTY: begin
          // in_ready is low only on the first cycle after reset; raise it here.
          in_ready <= 1'b1;
          if (in_fire) begin
            main_pc    <= pc_in;
            main_instr <= instruction_in;
            state      <= ONE;
            out_valid  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc    <= pc_in;
            main_instr <= instruction_in;
          end else if (in_fire) begin
            skid_pc    <= pc_in;
            skid_instr <= instruction_in;
            state      <= FULL;
            in_ready   <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
            state      <= ONE;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  // Counter width only matters when the perf counters are built.
  if (CNT_W > 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instruction_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instruction_out;
  logic [1:0]         occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pc_in(pc_in),
    .instruction_in(instruction_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pc_out(pc_out),
    .instruction_out(instruction_out),
    .occupancy(occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Instruction payload tagged with the PC so ordering errors show up in both fields.
  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [PC_W-1:0] pc, input logic ordy);
    flush          = f;
    in_valid       = iv;
    pc_in          = pc;
    instruction_in = instr_of(pc);
    out_ready      = ordy;
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [PC_W-1:0]  pc;
    logic             exp_ov;
    logic             exp_ir;
    logic [1:0]       exp_occ;
    logic [PC_W-1:0]  exp_pc;
    logic             chk_pay;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    logic [INSTR_W-1:0] exp_instr;

    //            fl   iv   ordy  pc          ov   ir   occ   pc_out      chk
    vecs[0]  = '{1'b0,1'b1,1'b1,32'h00,     1'b1,1'b1,2'd1,32'h00,     1'b1}; // stream
    vecs[1]  = '{1'b0,1'b1,1'b1,32'h04,     1'b1,1'b1,2'd1,32'h04,     1'b1};
    vecs[2]  = '{1'b0,1'b1,1'b1,32'h08,     1'b1,1'b1,2'd1,32'h08,     1'b1};
    vecs[3]  = '{1'b0,1'b1,1'b1,32'h0C,     1'b1,1'b1,2'd1,32'h0C,     1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h00,     1'b0,1'b1,2'd0,32'h00,     1'b0}; // drain
    vecs[5]  = '{1'b0,1'b1,1'b0,32'h10,     1'b1,1'b1,2'd1,32'h10,     1'b1}; // backpressure
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h14,     1'b1,1'b0,2'd2,32'h10,     1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h18,     1'b1,1'b0,2'd2,32'h10,     1'b1}; // not accepted
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h00,     1'b1,1'b1,2'd1,32'h14,     1'b1}; // 0x10 leaves
    vecs[9]  = '{1'b0,1'b1,1'b1,32'h20,     1'b1,1'b1,2'd1,32'h20,     1'b1}; // in&out in ONE
    vecs[10] = '{1'b0,1'b1,1'b0,32'h24,     1'b1,1'b0,2'd2,32'h20,     1'b1};
    vecs[11] = '{1'b1,1'b1,1'b0,32'h18,     1'b0,1'b1,2'd0,32'h00,     1'b1}; // flush at FULL
    vecs[12] = '{1'b0,1'b0,1'b0,32'h00,     1'b0,1'b1,2'd0,32'h00,     1'b1};
    vecs[13] = '{1'b0,1'b1,1'b1,32'h28,     1'b1,1'b1,2'd1,32'h28,     1'b1};
    vecs[14] = '{1'b1,1'b1,1'b1,32'h2C,     1'b0,1'b1,2'd0,32'h00,     1'b1}; // flush drops in_fire
    vecs[15] = '{1'b0,1'b0,1'b1,32'h00,     1'b0,1'b1,2'd0,32'h00,     1'b1};

    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_pc_out",    64'(pc_out),    64'd0);
    check("reset_instr_out", 64'(instruction_out), 64'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].out_ready);
      step();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      check($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].exp_ir));
      check($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      if (vecs[i].chk_pay) begin
        exp_instr = (vecs[i].exp_ov == 1'b0) ? '0 : instr_of(vecs[i].exp_pc);
        check($sformatf("vec%0d_pc_out", i),    64'(pc_out),          64'(vecs[i].exp_pc));
        check($sformatf("vec%0d_instr_out", i), 64'(instruction_out), 64'(exp_instr));
      end
    end

    // Asynchronous reset mid-stream while full.
    drive(1'b0, 1'b1, 32'h30, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h34, 1'b0);
    step();
    check("prereset_occupancy", 64'(occupancy), 64'd2);
    drive(1'b0, 1'b0, '0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd0);
    check("midreset_pc_out",    64'(pc_out),    64'd0);
    check("midreset_occupancy", 64'(occupancy), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    check("midreset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("rerelease_in_ready",  64'(in_ready),  64'd1);
    check("rerelease_occupancy", 64'(occupancy), 64'd0);

`ifdef PIPE_PERF_CNT_EN
    // Bubbles: the edge after release and the push edge both see out_valid=0.
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    check("perf_bubble_early", 64'(bubble_cnt), 64'd2);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("perf_stall_sat", 64'(stall_cnt), 64'd15);
    check("perf_pc_held",   64'(pc_out),    64'h40);
    drive(1'b1, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    check("perf_stall_after_flush", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 20; i++) step();
    check("perf_bubble_sat", 64'(bubble_cnt), 64'd15);
    check("perf_stall_still", 64'(stall_cnt), 64'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
